// File: rtl/pk_hasti.sv
// rtl/pk_hasti.sv - shared HASTI types, burst-length helper and arbiter constants
package pk_hasti;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_t;

    localparam int        CNT_W  = 4;
    localparam logic [7:0] NO_GNT = 8'h00;
    localparam logic [CNT_W-1:0] NO_CNT = '0;

    // Fixed-length bursts return their beat count; SINGLE and INCR return 0.
    function automatic logic [4:0] burst_beats(input hburst_t b);
        case (b)
            HBURST_WRAP4, HBURST_INCR4:   burst_beats = 5'd4;
            HBURST_WRAP8, HBURST_INCR8:   burst_beats = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: burst_beats = 5'd16;
            default:                      burst_beats = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/hasti_rr_pick.sv
// rtl/hasti_rr_pick.sv - combinational round-robin picker starting after the last winner
module hasti_rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!any && req[(int'(last) + k) % N]) begin
                any                           = 1'b1;
                idx                           = IW'((int'(last) + k) % N);
                onehot[(int'(last) + k) % N]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hasti_arbiter.sv
// rtl/hasti_arbiter.sv - round-robin HASTI arbiter with burst and lock hold
module hasti_arbiter
    import pk_hasti::*;
#(
    parameter int NMASTERS = 4,
    parameter int IW       = $clog2(NMASTERS)
) (
    input  logic                hclk,
    input  logic                hresetn,
    input  logic [NMASTERS-1:0] req,
    input  htrans_t             m_htrans,
    input  hburst_t             m_hburst,
    input  logic                m_hmastlock,
    input  logic                hready,
    output logic [NMASTERS-1:0] gnt_addr,
    output logic [NMASTERS-1:0] gnt_data,
    output logic [IW-1:0]       gnt_idx,
    output logic                hold
);

    logic [IW-1:0]       last;
    logic [IW-1:0]       own_idx;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                incr_act, incr_nxt;
    logic                lock_act, lock_nxt;
    logic [NMASTERS-1:0] pick_onehot;
    logic [IW-1:0]       pick_idx;
    logic                pick_any;
    logic                has_owner;
    logic [4:0]          beats;

    hasti_rr_pick #(
        .N  (NMASTERS),
        .IW (IW)
    ) u_pick (
        .req    (req),
        .last   (last),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Hold is purely registered so the grant never depends on the owner's own signals.
    assign hold      = (cnt != NO_CNT) || incr_act || lock_act;
    assign has_owner = hold || pick_any;
    assign beats     = burst_beats(m_hburst);

    always_comb begin
        gnt_addr = NO_GNT[NMASTERS-1:0];
        gnt_idx  = '0;
        if (hold) begin
            gnt_addr[own_idx] = 1'b1;
            gnt_idx           = own_idx;
        end else if (pick_any) begin
            gnt_addr = pick_onehot;
            gnt_idx  = pick_idx;
        end
    end

    always_comb begin
        cnt_nxt  = cnt;
        incr_nxt = incr_act;
        lock_nxt = lock_act;
        if (hready && has_owner) begin
            case (m_htrans)
                HTRANS_NONSEQ: begin
                    cnt_nxt  = (beats != 5'd0) ? CNT_W'(beats - 5'd1) : NO_CNT;
                    incr_nxt = (m_hburst == HBURST_INCR);
                    lock_nxt = m_hmastlock;
                end
                HTRANS_SEQ: begin
                    if (cnt != NO_CNT) begin
                        cnt_nxt = cnt - 1'b1;
                    end
                    lock_nxt = m_hmastlock;
                end
                // IDLE ends both fixed (abandoned) and INCR bursts; lock survives it.
                HTRANS_IDLE: begin
                    cnt_nxt  = NO_CNT;
                    incr_nxt = 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            last     <= IW'(NMASTERS - 1);
            own_idx  <= '0;
            cnt      <= NO_CNT;
            incr_act <= 1'b0;
            lock_act <= 1'b0;
            gnt_data <= '0;
        end else if (hready) begin
            cnt      <= cnt_nxt;
            incr_act <= incr_nxt;
            lock_act <= lock_nxt;
            gnt_data <= gnt_addr;
            if (!hold && pick_any) begin
                last    <= pick_idx;
                own_idx <= pick_idx;
            end
        end
    end

endmodule

// File: doc/hasti_arbiter.md
HASTI_ARBITER -- requirements
Module: hasti_arbiter

Interface
REQ-001 Parameter: NMASTERS, default 4, number of requesting HASTI masters (2..8).
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 hclk  input  1  bus clock, all state on rising edge.
REQ-004 hresetn  input  1  asynchronous active-low reset.
REQ-005 req  input  NMASTERS  per-master request (valid or skid-buffered transfer pending).
REQ-006 m_htrans  input  htrans_t  htrans of currently granted master, address phase.
REQ-007 m_hburst  input  hburst_t  hburst of currently granted master, address phase.
REQ-008 m_hmastlock  input  1  hmastlock of currently granted master.
REQ-009 hready  input  1  slave hreadyout; 1 = address phase accepted.
REQ-010 gnt_addr  output  NMASTERS  one-hot address-phase grant, all-zero = no grant.
REQ-011 gnt_data  output  NMASTERS  one-hot data-phase grant.
REQ-012 gnt_idx  output  $clog2(NMASTERS)  index of gnt_addr owner, 0 when no grant.
REQ-013 hold  output  1  grant frozen (burst or lock in progress).

Function
REQ-014 Arbitration point = cycle with hold=0; gnt_addr is combinational from req and rr pointer.
REQ-015 Round-robin: search starts at (last+1) mod NMASTERS, wraps, first set req bit wins.
REQ-016 Pointer last updates to winner at each clock edge where hready=1 and winner exists; unchanged otherwise.
REQ-017 While hold=1, gnt_addr = owner regardless of req.
REQ-018 hold sets on edge with hready=1, owner m_htrans=NONSEQ and m_hburst in {INCR4,WRAP4,INCR8,WRAP8,INCR16,WRAP16}; beat counter loads len-1 (3, 7 or 15).
REQ-019 Counter decrements on each edge with hready=1 and m_htrans=SEQ; BUSY does not decrement.
REQ-020 hold clears on edge where counter=1 and SEQ accepted; following cycle is arbitration point.
REQ-021 hburst=INCR: hold sets on accepted NONSEQ, clears on accepted IDLE or NONSEQ with hburst!=INCR; SINGLE never sets hold.
REQ-022 m_hmastlock=1 on accepted transfer sets hold; it clears only on accepted transfer with m_hmastlock=0 and no fixed-burst count remaining.
REQ-023 Owner presenting IDLE with hready=1 during fixed burst (abandoned burst): hold clears, counter zeroes, pointer unchanged.
REQ-024 gnt_data registers gnt_addr on every edge with hready=1; holds otherwise.
REQ-025 hready=0: counter, hold, pointer, gnt_data all frozen.
REQ-026 No req and hold=0: gnt_addr=0, gnt_idx=0.
REQ-027 req of owner dropping during hold does not release grant.

Reset
REQ-028 hresetn low: gnt_data=0, hold=0, counter=0, last=NMASTERS-1 (master 0 wins first), immediately, independent of hclk.
REQ-029 Reset mid-burst discards burst state; first post-reset cycle is an arbitration point.
REQ-030 Reset release synchronous to hclk by caller; block needs no internal synchronizer.

Structure
REQ-031 Burst-length function (hburst_t -> beats) and NO_GNT-style constants live in pk_hasti; htrans_t/hburst_t reused from it.
REQ-032 Combinational round-robin picker is sub-module hasti_rr_pick (req, last -> one-hot, index, any).
REQ-033 Arbiter replaces fixed priority in hasti_slave_mux; mux consumes gnt_addr/gnt_data.

Verification
REQ-034 NMASTERS=4, req=4'b1111 constant, hready=1, SINGLE -> grants 0,1,2,3,0 on consecutive cycles.
REQ-035 Master 1 INCR4 (NONSEQ,SEQ,SEQ,SEQ), req=4'b1111 -> gnt_addr=master 1 for 4 accepted beats, then master 2.
REQ-036 Master 0 WRAP8 with hready=0 for 3 cycles at beat 4 plus one BUSY -> counter frozen/not decremented, grant held exactly 8 SEQ/NONSEQ beats.
REQ-037 Master 3 hmastlock=1 for 5 transfers, req=4'b1111 -> gnt_idx=3 until first accepted transfer with hmastlock=0, then master 0.
REQ-038 Master 2 INCR16 abandoned with IDLE at beat 6 -> hold=0 next cycle, pointer=2, master 3 granted.
REQ-039 hresetn asserted during beat 2 of INCR8 -> gnt_data=0, hold=0 without clock edge; after release master 0 wins with req=4'b0001.
